// File: rtl/board_raster_gen.sv
// board_raster_gen
//   Streams the tic-tac-toe board bitmap one pixel per accepted beat, in raster
//   order. The image is built from grid lines, X/O marks and highlighted cells,
//   taken from a snapshot of the board vector latched when the frame starts.
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   i_start        pulse: begin one frame (only honoured while idle)
//   i_board        2 bits per cell, cell i = cy*COLS+cx at [2i+1:2i]
//                  00 empty, 01 X, 10 O, 11 highlight
//   o_busy         a frame is in progress
//   o_out_valid    pixel beat valid; i_out_ready accepts it
//   o_out_pix      1 = background, 0 = ink
//   o_out_sof      beat is pixel (0,0)
//   o_out_eol      beat is the last pixel of a row
//   o_out_eof      beat is the last pixel of the frame
//   o_frame_done   one-cycle pulse after the eof beat is accepted
module board_raster_gen #(
  parameter int COLS       = 5,
  parameter int ROWS       = 3,
  parameter int CELL_SZ    = 26,
  parameter int LINE_W     = 1,
  parameter int MARGIN     = 4,
  parameter int MARK_W     = 2,
  parameter int CONTINUOUS = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic [2*ROWS*COLS-1:0]   i_board,
  output logic                     o_busy,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic                     o_out_pix,
  output logic                     o_out_sof,
  output logic                     o_out_eol,
  output logic                     o_out_eof,
  output logic                     o_frame_done
);

  localparam int PITCH = CELL_SZ + LINE_W;
  localparam int W     = COLS * PITCH;
  localparam int H     = ROWS * PITCH;
  localparam int NC    = ROWS * COLS;
  localparam int BW    = 2 * NC;
  localparam int XW    = $clog2(W);
  localparam int YW    = $clog2(H);
  localparam int PW    = $clog2(PITCH);
  localparam int CXW   = $clog2(COLS > 1 ? COLS : 2);
  localparam int CYW   = $clog2(ROWS > 1 ? ROWS : 2);
  localparam int IW    = $clog2(NC > 1 ? NC : 2);
  // Wide enough for lx+ly without overflow.
  localparam int LW    = PW + 2;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_load;
  logic            w_latch;
  logic            w_drop;
  logic            w_done;

  logic [BW-1:0]   r_snap;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [PW-1:0]   r_lx;
  logic [PW-1:0]   r_ly;
  logic [CXW-1:0]  r_cx;
  logic [CYW-1:0]  r_cy;

  logic            r_busy;
  logic            r_out_valid;
  logic            r_out_pix;
  logic            r_out_sof;
  logic            r_out_eol;
  logic            r_out_eof;
  logic            r_frame_done;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // The output registers are the single pipeline stage: the counters always
  // point at the next pixel to load, and a load happens on start or whenever
  // the presented beat is accepted.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_latch      = 1'b0;
    w_drop       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = ST_RUN;
          w_load       = 1'b1;
          w_latch      = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_out_valid && i_out_ready) begin
          if (r_out_eof) begin
            w_done = 1'b1;
            if (CONTINUOUS != 0) begin
              w_load  = 1'b1;
              w_latch = 1'b1;
            end else begin
              w_state_next = ST_IDLE;
              w_drop       = 1'b1;
            end
          end else begin
            w_load = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------- cell lookup
  // When the snapshot is being (re)latched this cycle the first pixel of the
  // new frame must already see the incoming board.
  logic [BW-1:0] w_src;
  logic [1:0]    w_cells [NC];
  logic [IW-1:0] w_idx;
  logic [1:0]    w_code;

  assign w_src = w_latch ? i_board : r_snap;

  for (genvar gi = 0; gi < NC; gi++) begin : g_cell
    assign w_cells[gi] = w_src[2*gi +: 2];
  end

  assign w_idx  = IW'(r_cy) * IW'(COLS) + IW'(r_cx);
  assign w_code = w_cells[w_idx];

  // ------------------------------------------------------------ pixel
  logic [LW-1:0] w_lx, w_ly_raw, w_ly, w_d1, w_sum, w_d2;
  logic          w_grid, w_in_box, w_x_ink, w_o_ink, w_mark, w_pix;
  logic          w_sof, w_eol, w_eof;

  always_comb begin
    w_lx     = LW'(r_lx);
    w_ly_raw = LW'(r_ly);
    w_grid   = (w_ly_raw < LW'(LINE_W)) || (w_lx >= LW'(CELL_SZ));
    // Only meaningful off the grid, where ly_raw >= LINE_W.
    w_ly     = w_ly_raw - LW'(LINE_W);
    w_in_box = (w_lx >= LW'(MARGIN)) && (w_lx <= LW'(CELL_SZ - 1 - MARGIN)) &&
               (w_ly >= LW'(MARGIN)) && (w_ly <= LW'(CELL_SZ - 1 - MARGIN));
    w_d1     = (w_lx >= w_ly) ? (w_lx - w_ly) : (w_ly - w_lx);
    w_sum    = w_lx + w_ly;
    w_d2     = (w_sum >= LW'(CELL_SZ - 1)) ? (w_sum - LW'(CELL_SZ - 1))
                                           : (LW'(CELL_SZ - 1) - w_sum);
    w_x_ink  = w_in_box && ((w_d1 < LW'(MARK_W)) || (w_d2 < LW'(MARK_W)));
    w_o_ink  = w_in_box &&
               ((w_lx < LW'(MARGIN + MARK_W)) || (w_lx > LW'(CELL_SZ - 1 - MARGIN - MARK_W)) ||
                (w_ly < LW'(MARGIN + MARK_W)) || (w_ly > LW'(CELL_SZ - 1 - MARGIN - MARK_W)));
    case (w_code)
      2'b01:   w_mark = w_x_ink;
      2'b10:   w_mark = w_o_ink;
      2'b11:   w_mark = 1'b1;
      default: w_mark = 1'b0;
    endcase
    w_pix = !(w_grid || w_mark);
    w_sof = (r_x == '0) && (r_y == '0);
    w_eol = (r_x == XW'(W - 1));
    w_eof = w_eol && (r_y == YW'(H - 1));
  end

  // ------------------------------------------------ datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap       <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_lx         <= '0;
      r_ly         <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_busy       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_pix    <= 1'b0;
      r_out_sof    <= 1'b0;
      r_out_eol    <= 1'b0;
      r_out_eof    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_busy       <= (w_state_next == ST_RUN);
      r_frame_done <= w_done;
      if (w_latch) r_snap <= i_board;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_pix   <= w_pix;
        r_out_sof   <= w_sof;
        r_out_eol   <= w_eol;
        r_out_eof   <= w_eof;
        // Advance position; all counters wrap to 0 after the last pixel so
        // the next frame starts from (0,0) without extra clearing.
        if (w_eol) begin
          r_x  <= '0;
          r_lx <= '0;
          r_cx <= '0;
          if (w_eof) begin
            r_y  <= '0;
            r_ly <= '0;
            r_cy <= '0;
          end else begin
            r_y <= r_y + 1'b1;
            if (r_ly == PW'(PITCH - 1)) begin
              r_ly <= '0;
              r_cy <= r_cy + 1'b1;
            end else begin
              r_ly <= r_ly + 1'b1;
            end
          end
        end else begin
          r_x <= r_x + 1'b1;
          if (r_lx == PW'(PITCH - 1)) begin
            r_lx <= '0;
            r_cx <= r_cx + 1'b1;
          end else begin
            r_lx <= r_lx + 1'b1;
          end
        end
      end else if (w_drop) begin
        r_out_valid <= 1'b0;
        r_out_pix   <= 1'b0;
        r_out_sof   <= 1'b0;
        r_out_eol   <= 1'b0;
        r_out_eof   <= 1'b0;
      end
    end
  end

  assign o_busy       = r_busy;
  assign o_out_valid  = r_out_valid;
  assign o_out_pix    = r_out_pix;
  assign o_out_sof    = r_out_sof;
  assign o_out_eol    = r_out_eol;
  assign o_out_eof    = r_out_eof;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_board_raster_gen.sv
// tb_board_raster_gen
//   Directed sequence with randomized board contents and sink back-pressure,
//   checked beat by beat against a reference image computed with plain
//   division/modulo arithmetic. Two instances: one-shot and continuous.
module tb_board_raster_gen;

  localparam int COLS    = 5;
  localparam int ROWS    = 3;
  localparam int CELL_SZ = 26;
  localparam int LINE_W  = 1;
  localparam int MARGIN  = 4;
  localparam int MARK_W  = 2;
  localparam int PITCH   = CELL_SZ + LINE_W;
  localparam int W       = COLS * PITCH;
  localparam int H       = ROWS * PITCH;
  localparam int NPIX    = W * H;
  localparam int BW      = 2 * ROWS * COLS;
  localparam int BUDGET  = 40000;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b1;
  logic          start0 = 1'b0;
  logic          start1 = 1'b0;
  logic          ready  = 1'b0;
  logic [BW-1:0] board  = '0;

  logic busy0, valid0, pix0, sof0, eol0, eof0, done0;
  logic busy1, valid1, pix1, sof1, eol1, eof1, done1;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   sel     = 0;
  bit   cap [NPIX];

  logic o_busy, o_valid, o_pix, o_sof, o_eol, o_eof, o_done;

  always #5 clk = ~clk;

  board_raster_gen #(.CONTINUOUS(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_start(start0), .i_board(board),
    .o_busy(busy0), .o_out_valid(valid0), .i_out_ready(ready),
    .o_out_pix(pix0), .o_out_sof(sof0), .o_out_eol(eol0), .o_out_eof(eof0),
    .o_frame_done(done0)
  );

  board_raster_gen #(.CONTINUOUS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start1), .i_board(board),
    .o_busy(busy1), .o_out_valid(valid1), .i_out_ready(ready),
    .o_out_pix(pix1), .o_out_sof(sof1), .o_out_eol(eol1), .o_out_eof(eof1),
    .o_frame_done(done1)
  );

  always_comb begin
    {o_busy, o_valid, o_pix, o_sof, o_eol, o_eof, o_done} = {busy0, valid0, pix0, sof0, eol0, eof0, done0};
    if (sel == 1)
      {o_busy, o_valid, o_pix, o_sof, o_eol, o_eof, o_done} = {busy1, valid1, pix1, sof1, eol1, eof1, done1};
  end

  task automatic chk(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s idx=%0d observed=%0h expected=%0h", tag, idx, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference image: pixel value from the drawing rules, using x/y directly.
  function automatic logic ref_pix(input logic [BW-1:0] b, input int x, input int y);
    int lxr, lyr, lx, ly, code, lo, hi;
    bit inbox, ink;
    lxr = x % PITCH;
    lyr = y % PITCH;
    if (lyr < LINE_W || lxr >= CELL_SZ) return 1'b0;
    lx   = lxr;
    ly   = lyr - LINE_W;
    code = int'((b >> (2 * ((y / PITCH) * COLS + x / PITCH))) & BW'(3));
    lo   = MARGIN;
    hi   = CELL_SZ - 1 - MARGIN;
    inbox = (lx >= lo) && (lx <= hi) && (ly >= lo) && (ly <= hi);
    case (code)
      1:       ink = inbox && (iabs(lx - ly) < MARK_W || iabs(lx + ly - (CELL_SZ - 1)) < MARK_W);
      2:       ink = inbox && (lx - lo < MARK_W || hi - lx < MARK_W || ly - lo < MARK_W || hi - ly < MARK_W);
      3:       ink = 1'b1;
      default: ink = 1'b0;
    endcase
    return !ink;
  endfunction

  // {pix, sof, eol, eof} expected for beat n of a frame.
  function automatic logic [3:0] ref_beat(input logic [BW-1:0] b, input int n);
    int x, y;
    x = n % W;
    y = n / W;
    return {ref_pix(b, x, y), n == 0, x == W - 1, n == NPIX - 1};
  endfunction

  // Runs one frame on the selected instance, starting and ending right after
  // a clock edge. Optional: random ready, mid-frame board change + start
  // pulse at beat 500, and asynchronous reset at beat abort_at.
  task automatic run_frame(input bit do_start, input logic [BW-1:0] exp_b, input bit rnd,
                           input bit disturb, input logic [BW-1:0] new_b, input int abort_at);
    int         n = 0;
    int         cyc = 0;
    bit         held = 0;
    bit         disturbed = 0;
    logic [3:0] held_val = '0;
    logic [3:0] cur;
    logic       rdy;
    if (do_start) begin
      @(posedge clk); #1;
      if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      start1 = 1'b0;
      chk("start_latency", 0, 32'({o_valid, o_busy}), 32'b11);
    end
    while (n < NPIX) begin
      if (n == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", n, 32'({o_busy, o_valid, o_pix, o_sof, o_eol, o_eof, o_done}), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("after_abort_idle", n, 32'({o_busy, o_valid, o_done}), 32'd0);
        return;
      end
      cur = {o_pix, o_sof, o_eol, o_eof};
      chk("valid_no_bubble", n, 32'(o_valid), 32'd1);
      if (held) chk("stall_hold", n, 32'(cur), 32'(held_val));
      rdy   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ready = rdy;
      if (disturb && !disturbed && n == 500) begin
        disturbed = 1;
        board = new_b;
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
      end
      if (o_valid && rdy) begin
        chk("beat", n, 32'(cur), 32'(ref_beat(exp_b, n)));
        cap[n] = o_pix;
        n++;
        held = 0;
      end else begin
        held     = 1;
        held_val = cur;
      end
      @(posedge clk); #1;
      start0 = 1'b0;
      start1 = 1'b0;
      cyc++;
      if (cyc > BUDGET) begin
        chk("frame_timeout", n, 32'(n), 32'(NPIX));
        return;
      end
    end
    chk("frame_done_pulse", n, 32'(o_done), 32'd1);
    if (sel == 1)
      chk("cont_next_sof", n, 32'({o_valid, o_sof}), 32'b11);
    else
      chk("idle_after_eof", n, 32'({o_valid, o_busy}), 32'd0);
  endtask

  task automatic spot(input string tag, input int x, input int y, input bit exp);
    chk(tag, y * W + x, 32'(cap[y * W + x]), 32'(exp));
  endtask

  initial begin
    logic [BW-1:0] b1, b2;
    int            ones;

    // Reset state
    #1 rst_n = 1'b0;
    #1 chk("reset_dut0", 0, 32'({busy0, valid0, pix0, sof0, eol0, eof0, done0}), 32'd0);
    chk("reset_dut1", 0, 32'({busy1, valid1, pix1, sof1, eol1, eof1, done1}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", 0, 32'({busy0, valid0, done0}), 32'd0);

    // Empty board, ready always high
    sel   = 0;
    board = '0;
    run_frame(1, '0, 0, 0, '0, -1);
    spot("empty_0_0", 0, 0, 1'b0);
    spot("empty_0_1", 0, 1, 1'b1);
    spot("empty_26_5", 26, 5, 1'b0);
    spot("empty_27_0", 27, 0, 1'b0);
    spot("empty_134_80", 134, 80, 1'b0);
    spot("empty_133_80", 133, 80, 1'b1);

    // X in cell 0, O in cell 1, highlight in cell 7; random back-pressure,
    // board change and stray start mid-frame
    b1 = BW'($urandom);
    b1[1:0]   = 2'b01;
    b1[3:2]   = 2'b10;
    b1[15:14] = 2'b11;
    b2 = BW'($urandom);
    board = b1;
    run_frame(1, b1, 1, 1, b2, -1);
    spot("x_4_5", 4, 5, 1'b0);
    spot("x_5_7", 5, 7, 1'b0);
    spot("x_10_5", 10, 5, 1'b1);
    spot("x_21_5", 21, 5, 1'b0);
    spot("x_3_5", 3, 5, 1'b1);
    spot("o_31_10", 31, 10, 1'b0);
    spot("o_40_15", 40, 15, 1'b1);
    spot("o_30_15", 30, 15, 1'b1);
    ones = 0;
    for (int y = PITCH + LINE_W; y < 2 * PITCH; y++)
      for (int x = 2 * PITCH; x < 2 * PITCH + CELL_SZ; x++)
        ones += int'(cap[y * W + x]);
    chk("highlight_cell7", 0, 32'(ones), 32'd0);

    // Reset mid-frame, then a clean frame
    board = BW'($urandom);
    run_frame(1, board, 0, 0, '0, 3000);
    board = BW'($urandom);
    run_frame(1, board, 0, 0, '0, -1);

    // Continuous instance: the second frame picks up the board changed mid-way
    sel = 1;
    b1 = BW'($urandom);
    b2 = BW'($urandom);
    board = b1;
    run_frame(1, b1, 0, 1, b2, -1);
    run_frame(0, b2, 0, 0, '0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
